// File: rtl/seq_div_pkg.sv
// ---------------------------------------------------------------------------
// seq_div_pkg
// Shared types and constants for the sequential restoring divider.
//   state_e        : controller states (IDLE / CALC / DONE)
//   DEF_N          : default divisor/remainder width
//   DW / RW / CW   : dividend/quotient width, partial-remainder width and
//                    step-counter width for the default N
//   DIV0_QUOTIENT  : quotient reported for a zero divisor (unsigned build)
// ---------------------------------------------------------------------------
package seq_div_pkg;

    localparam int DEF_N = 6;
    localparam int DW    = 2 * DEF_N;
    localparam int RW    = DEF_N + 1;
    localparam int CW    = $clog2(DW);

    localparam logic [DW-1:0] DIV0_QUOTIENT = {DW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : seq_div_pkg

// File: rtl/seq_divider_div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   i_rem     [N:0]   partial remainder before the step
//   i_bit             next dividend bit shifted into the remainder
//   i_divisor [N-1:0] divisor magnitude
//   o_rem     [N:0]   partial remainder after the step
//   o_q               quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step #(
    parameter int N = 6
) (
    input  logic [N:0]   i_rem,
    input  logic         i_bit,
    input  logic [N-1:0] i_divisor,
    output logic [N:0]   o_rem,
    output logic         o_q
);

    logic [N:0] w_shift;
    logic [N:0] w_dvs_ext;
    logic [N:0] w_diff;

    // Trial subtraction on N+1 bits. i_rem[N] is the bit that would fall off
    // the shift; if it is set the shifted value certainly exceeds the divisor,
    // and the modular difference is still the exact result.
    always_comb begin
        w_shift   = {i_rem[N-1:0], i_bit};
        w_dvs_ext = {1'b0, i_divisor};
        w_diff    = w_shift - w_dvs_ext;
        o_q       = i_rem[N] | (w_shift >= w_dvs_ext);
        if (o_q) begin
            o_rem = w_diff;
        end else begin
            o_rem = w_shift;
        end
    end

endmodule : div_step

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock, start/busy/done handshake.
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request, sampled only in IDLE
//   dividend [2N-1:0]   numerator, captured when start is accepted
//   divisor  [N-1:0]    denominator, captured when start is accepted
//   busy                high while computing
//   done                one-cycle pulse, results valid
//   quotient [2N-1:0]   registered result, held until the next accepted start
//   remainder[N-1:0]    registered result, held until the next accepted start
//   div_by_zero         registered flag, held with the results
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands
// (truncating division, remainder takes the dividend's sign).
// ---------------------------------------------------------------------------
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero
);

    localparam int QW  = 2 * N;
    localparam int RWL = N + 1;
    localparam int CWL = $clog2(2 * N);
    localparam logic [CWL-1:0] CNT_LAST = CWL'(QW - 1);
    localparam logic [CWL-1:0] CNT_ONE  = {{(CWL-1){1'b0}}, 1'b1};

    state_e         r_state;
    state_e         w_next_state;

    logic [QW-1:0]  r_dvd;      // dividend bits shift out, quotient bits shift in
    logic [RWL-1:0] r_rem;
    logic [N-1:0]   r_dvs;
    logic [CWL-1:0] r_cnt;

    logic [RWL-1:0] w_step_rem;
    logic           w_step_q;
    logic           w_div0;
    logic           w_last;
    logic [QW-1:0]  w_load_dvd;
    logic [N-1:0]   w_load_dvs;
    logic [QW-1:0]  w_q_raw;
    logic [N-1:0]   w_r_raw;
    logic [QW-1:0]  w_q_final;
    logic [N-1:0]   w_r_final;
    logic [QW-1:0]  w_q_div0;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic           r_neg_q;
    logic           r_neg_r;
`endif

    div_step #(.N(N)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[QW-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_step_rem),
        .o_q       (w_step_q)
    );

    // Decode of the divide-by-zero request and the final CALC step.
    always_comb begin
        w_div0  = (divisor == {N{1'b0}});
        w_last  = (r_state == CALC) && (r_cnt == CNT_LAST);
        w_q_raw = {r_dvd[QW-2:0], w_step_q};
        w_r_raw = w_step_rem[N-1:0];
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    // Operand magnitudes at load, sign correction at the result write.
    always_comb begin
        if (dividend[QW-1]) begin
            w_load_dvd = -dividend;
            w_q_div0   = {{(QW-1){1'b0}}, 1'b1};
        end else begin
            w_load_dvd = dividend;
            w_q_div0   = {QW{1'b1}};
        end
        if (divisor[N-1]) begin
            w_load_dvs = -divisor;
        end else begin
            w_load_dvs = divisor;
        end
        if (r_neg_q) begin
            w_q_final = -w_q_raw;
        end else begin
            w_q_final = w_q_raw;
        end
        if (r_neg_r) begin
            w_r_final = -w_r_raw;
        end else begin
            w_r_final = w_r_raw;
        end
    end
`else
    // Unsigned build: operands and results pass straight through.
    always_comb begin
        w_load_dvd = dividend;
        w_load_dvs = divisor;
        w_q_div0   = {QW{1'b1}};
        w_q_final  = w_q_raw;
        w_r_final  = w_r_raw;
    end
`endif

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Controller next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_div0) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = CALC;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = CALC;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Work registers: operand capture in IDLE, one restoring step per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd <= {QW{1'b0}};
            r_rem <= {RWL{1'b0}};
            r_dvs <= {N{1'b0}};
            r_cnt <= {CWL{1'b0}};
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !w_div0) begin
                        r_dvd <= w_load_dvd;
                        r_dvs <= w_load_dvs;
                        r_rem <= {RWL{1'b0}};
                        r_cnt <= {CWL{1'b0}};
`ifdef SEQ_DIVIDER_SIGNED_EN
                        r_neg_q <= dividend[QW-1] ^ divisor[N-1];
                        r_neg_r <= dividend[QW-1];
`endif
                    end
                end
                CALC: begin
                    r_dvd <= w_q_raw;
                    r_rem <= w_step_rem;
                    r_cnt <= r_cnt + CNT_ONE;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Registered handshake and results; results change only on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {QW{1'b0}};
            remainder   <= {N{1'b0}};
            div_by_zero <= 1'b0;
        end else begin
            busy <= (w_next_state == CALC);
            done <= (w_next_state == DONE);
            if ((r_state == IDLE) && start && w_div0) begin
                quotient    <= w_q_div0;
                remainder   <= dividend[N-1:0];
                div_by_zero <= 1'b1;
            end else if (w_last) begin
                quotient    <= w_q_final;
                remainder   <= w_r_final;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
// Directed self-checking bench for seq_divider (N = 6).
// ---------------------------------------------------------------------------
module tb_seq_divider;

    localparam int N = 6;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;

    int n_pass  = 0;
    int n_total = 0;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Launch one division and check latency, busy length, results, done width.
    task automatic run_div(input string tag, input logic [2*N-1:0] a, input logic [N-1:0] b,
                           input logic [2*N-1:0] eq, input logic [N-1:0] er, input logic ez,
                           input int elat, input int ebusy);
        int cyc;
        int bcnt;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;          // operands may change after acceptance
        divisor  = b + 6'd5;
        cyc  = 1;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 50) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, elat);
        chk({tag, "_busy_cycles"}, bcnt, ebusy);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_div_by_zero"}, div_by_zero, ez);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, done, 1'b0);
        chk({tag, "_quotient_held"}, quotient, eq);
    endtask

    initial begin
        int cyc;
        int ndone;
        int done_cyc;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 12'd0;
        divisor  = 6'd0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_quotient", quotient, 12'd0);
        chk("reset_remainder", remainder, 6'd0);
        chk("reset_div_by_zero", div_by_zero, 1'b0);
        rst_n = 1'b1;

        run_div("d143_11", 12'd143, 6'd11, 12'd13, 6'd0, 1'b0, 13, 12);
`ifndef SEQ_DIVIDER_SIGNED_EN
        run_div("d4095_1", 12'd4095, 6'd1, 12'd4095, 6'd0, 1'b0, 13, 12);
        run_div("d3969_63", 12'd3969, 6'd63, 12'd63, 6'd0, 1'b0, 13, 12);
`endif
        run_div("d100_7", 12'd100, 6'd7, 12'd14, 6'd2, 1'b0, 13, 12);
        run_div("d100_0", 12'd100, 6'd0, 12'd4095, 6'd36, 1'b1, 1, 0);
        run_div("d143_11_clr", 12'd143, 6'd11, 12'd13, 6'd0, 1'b0, 13, 12);

        // Second start during CALC must be ignored.
        @(negedge clk);
        dividend = 12'd100;
        divisor  = 6'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        ndone    = 0;
        done_cyc = 0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (done === 1'b1) begin
                ndone++;
                done_cyc = cyc;
            end
            if (cyc == 4) begin
                dividend = 12'd4000;
                divisor  = 6'd3;
                start    = 1'b1;
            end else begin
                start    = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        chk("midstart_done_count", ndone, 1);
        chk("midstart_done_cycle", done_cyc, 13);
        chk("midstart_quotient", quotient, 12'd14);
        chk("midstart_remainder", remainder, 6'd2);

        // Asynchronous reset during CALC aborts without done.
        @(negedge clk);
        dividend = 12'd143;
        divisor  = 6'd11;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_quotient", quotient, 12'd0);
        chk("abort_remainder", remainder, 6'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        run_div("d100_7_after", 12'd100, 6'd7, 12'd14, 6'd2, 1'b0, 13, 12);

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_div("s_m100_7", 12'd3996, 6'd7, 12'd4082, 6'd62, 1'b0, 13, 12);
        run_div("s_m2048_m1", 12'd2048, 6'd63, 12'd2048, 6'd0, 1'b0, 13, 12);
        run_div("s_m100_0", 12'd3996, 6'd0, 12'd1, 6'd28, 1'b1, 1, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_seq_divider
